// File: rtl/count_uart_tx.sv
// count_uart_tx: snapshots an 8-bit count and sends it as two ASCII hex
// characters, optionally followed by CR, over an 8N1 UART line.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int APPEND_CR    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] count_in,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [1:0]    LAST_CHAR = (APPEND_CR != 0) ? 2'd2 : 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    char_q, char_d;
    logic [7:0]    snap_q, snap_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    cur_byte;
    logic          baud_end;
    logic [2:0]    bit_nx;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    assign baud_end = (baud_q == BAUD_MAX);
    assign bit_nx   = bit_q + 3'd1;

    // Character currently being framed, taken from the latched snapshot.
    always_comb begin
        cur_byte = 8'h0D;
        case (char_q)
            2'd0:    cur_byte = hex_ascii(snap_q[7:4]);
            2'd1:    cur_byte = hex_ascii(snap_q[3:0]);
            default: cur_byte = 8'h0D;
        endcase
    end

    // Next-state and registered-output logic; ena low holds everything.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (send) begin
                        snap_d  = count_in;
                        char_d  = 2'd0;
                        bit_d   = 3'd0;
                        baud_d  = '0;
                        state_d = START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_d  = '0;
                        bit_d   = 3'd0;
                        state_d = DATA;
                        tx_d    = cur_byte[0];
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_d = '0;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d = bit_nx;
                            tx_d  = cur_byte[bit_nx];
                        end
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_d = '0;
                        if (char_q == LAST_CHAR) begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            char_d  = char_q + 2'd1;
                            state_d = START;
                            tx_d    = 1'b0;
                        end
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
            endcase
        end
    end

    // State, counters, snapshot and outputs; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            char_q  <= 2'd0;
            snap_q  <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx: randomized self-checking bench for count_uart_tx,
// comparing waveforms and decoded bytes against a frame-arithmetic model.
module tb_count_uart_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       ena      = 1'b1;
    logic [7:0] count_in = 8'h00;
    logic       send     = 1'b0;

    logic tx0, busy0, done0;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;
    logic tx_s, busy_s, done_s;

    int sel     = 0;
    int n_pass  = 0;
    int n_total = 0;

    logic       cap_tx   [0:1023];
    logic       cap_busy [0:1023];
    logic       cap_done [0:1023];
    logic       cap_ena  [0:1024];
    logic       eff_tx   [0:1023];
    int         eff_len;
    logic [7:0] dec      [0:3];

    always #5 clk = ~clk;

    count_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CR(1)) u_c4_cr (
        .clk(clk), .rst_n(rst_n), .ena(ena), .count_in(count_in),
        .send(send), .tx(tx0), .busy(busy0), .done(done0)
    );

    count_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CR(0)) u_c4_nc (
        .clk(clk), .rst_n(rst_n), .ena(ena), .count_in(count_in),
        .send(send), .tx(tx1), .busy(busy1), .done(done1)
    );

    count_uart_tx #(.CLKS_PER_BIT(16), .APPEND_CR(1)) u_c16_cr (
        .clk(clk), .rst_n(rst_n), .ena(ena), .count_in(count_in),
        .send(send), .tx(tx2), .busy(busy2), .done(done2)
    );

    assign tx_s   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : tx2;
    assign busy_s = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    assign done_s = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] exp_char(input logic [7:0] v, input int i);
        if (i == 0) return hexc(v[7:4]);
        if (i == 1) return hexc(v[3:0]);
        return 8'h0D;
    endfunction

    // Expected line level j enabled cycles after acceptance.
    function automatic logic exp_tx(input logic [7:0] v, input int c,
                                    input int n, input int j);
        int f;
        int p;
        logic [7:0] b;
        if (j >= n * 10 * c) return 1'b1;
        f = j / (10 * c);
        p = (j % (10 * c)) / c;
        b = exp_char(v, f);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p - 1];
    endfunction

    task automatic wait_idle();
        int t = 0;
        send = 1'b0;
        ena  = 1'b1;
        while ((busy0 || busy1 || busy2) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if ((busy0 || busy1 || busy2) !== 1'b0)
            $display("FAIL wait_idle: busy=%b%b%b after %0d cycles, want 000",
                     busy0, busy1, busy2, t);
        else
            n_pass++;
        @(negedge clk);
    endtask

    // Send v, then record ncyc samples; ena is low for edges fs..fs+fl-1.
    task automatic capture(input logic [7:0] v, input int ncyc,
                           input int fs, input int fl, input bit hold);
        @(negedge clk);
        count_in = v;
        send     = 1'b1;
        ena      = 1'b1;
        @(negedge clk);
        if (!hold) send = 1'b0;
        cap_ena[0] = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            cap_tx[k]   = tx_s;
            cap_busy[k] = busy_s;
            cap_done[k] = done_s;
            ena = !((k + 1) >= fs && (k + 1) < fs + fl);
            cap_ena[k + 1] = ena;
            if (hold) count_in = (k >= 20) ? 8'h34 : 8'h12;
            else      count_in = 8'($urandom);
            @(negedge clk);
        end
        ena = 1'b1;
        eff_len = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == 0 || cap_ena[k]) begin
                eff_tx[eff_len] = cap_tx[k];
                eff_len++;
            end
        end
    endtask

    // UART receiver: find each start bit, sample at bit centres.
    task automatic decode(input int c, input int nb);
        int i = 0;
        for (int b = 0; b < nb; b++) begin
            dec[b] = 8'h00;
            while (i < eff_len && eff_tx[i] !== 1'b0) i++;
            i += c / 2;
            for (int d = 0; d < 8; d++)
                dec[b][d] = (i + (d + 1) * c < eff_len) ? eff_tx[i + (d + 1) * c] : 1'bx;
            i += 9 * c;
        end
    endtask

    task automatic test_reset();
        ena      = 1'b1;
        send     = 1'b1;
        count_in = 8'h55;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({tx0, busy0, done0} !== 3'b100)
            $display("FAIL reset_c4cr: tx/busy/done=%b want 100", {tx0, busy0, done0});
        else n_pass++;
        n_total++;
        if ({tx1, busy1, done1} !== 3'b100)
            $display("FAIL reset_c4nc: tx/busy/done=%b want 100", {tx1, busy1, done1});
        else n_pass++;
        n_total++;
        if ({tx2, busy2, done2} !== 3'b100)
            $display("FAIL reset_c16: tx/busy/done=%b want 100", {tx2, busy2, done2});
        else n_pass++;
        send  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({tx0, busy0, done0} !== 3'b100)
            $display("FAIL reset_idle: tx/busy/done=%b want 100", {tx0, busy0, done0});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] v = 8'h3A;
        int errs  = 0;
        int nb    = 0;
        int nd    = 0;
        int dpos  = -1;
        wait_idle();
        sel = 0;
        capture(v, 123, 0, 0, 1'b0);
        for (int k = 0; k < 123; k++) begin
            if (cap_tx[k] !== exp_tx(v, 4, 3, k) || cap_busy[k] !== (k < 120) ||
                cap_done[k] !== (k == 120)) errs++;
            if (cap_busy[k]) nb++;
            if (cap_done[k]) begin
                nd++;
                dpos = k;
            end
        end
        decode(4, 3);
        n_total++;
        if (errs != 0) $display("FAIL basic_wave: %0d bad samples, want 0", errs);
        else n_pass++;
        n_total++;
        if (nb != 120) $display("FAIL basic_busy_len: got %0d want 120", nb);
        else n_pass++;
        n_total++;
        if (nd != 1 || dpos != 120)
            $display("FAIL basic_done: count %0d at %0d, want 1 at 120", nd, dpos);
        else n_pass++;
        n_total++;
        if ({cap_tx[0], cap_tx[40], cap_tx[80]} !== 3'b000)
            $display("FAIL basic_starts: tx@0,40,80=%b want 000",
                     {cap_tx[0], cap_tx[40], cap_tx[80]});
        else n_pass++;
        for (int b = 0; b < 3; b++) begin
            n_total++;
            if (dec[b] !== exp_char(v, b))
                $display("FAIL basic_byte%0d: got %h want %h", b, dec[b], exp_char(v, b));
            else n_pass++;
        end
    endtask

    task automatic test_hex_bounds();
        logic [7:0] vals [0:5];
        logic [7:0] v;
        int errs;
        int nb;
        vals[0] = 8'h09;
        vals[1] = 8'hF0;
        vals[2] = 8'hFF;
        vals[3] = 8'($urandom);
        vals[4] = 8'($urandom);
        vals[5] = 8'($urandom);
        for (int t = 0; t < 6; t++) begin
            v    = vals[t];
            errs = 0;
            nb   = 0;
            wait_idle();
            sel = 1;
            capture(v, 83, 0, 0, 1'b0);
            for (int k = 0; k < 83; k++) begin
                if (cap_tx[k] !== exp_tx(v, 4, 2, k) || cap_busy[k] !== (k < 80) ||
                    cap_done[k] !== (k == 80)) errs++;
                if (cap_busy[k]) nb++;
            end
            decode(4, 2);
            n_total++;
            if (errs != 0) $display("FAIL hex_wave %h: %0d bad samples, want 0", v, errs);
            else n_pass++;
            n_total++;
            if (nb != 80) $display("FAIL hex_busy %h: got %0d want 80", v, nb);
            else n_pass++;
            for (int b = 0; b < 2; b++) begin
                n_total++;
                if (dec[b] !== exp_char(v, b))
                    $display("FAIL hex_byte %h/%0d: got %h want %h", v, b, dec[b], exp_char(v, b));
                else n_pass++;
            end
        end
    endtask

    task automatic test_busy_reject();
        int errs  = 0;
        int nlow  = 0;
        int j;
        logic [7:0] w;
        logic [7:0] want [0:3];
        want[0] = 8'h31;
        want[1] = 8'h32;
        want[2] = 8'h33;
        want[3] = 8'h34;
        wait_idle();
        sel = 1;
        capture(8'h12, 162, 0, 0, 1'b1);
        send = 1'b0;
        for (int k = 0; k < 162; k++) begin
            w = (k <= 80) ? 8'h12 : 8'h34;
            j = (k <= 80) ? k : k - 81;
            if (cap_tx[k] !== exp_tx(w, 4, 2, j) || cap_busy[k] !== (j < 80) ||
                cap_done[k] !== (j == 80)) errs++;
            if (k <= 160 && !cap_busy[k]) nlow++;
        end
        decode(4, 4);
        n_total++;
        if (errs != 0) $display("FAIL reject_wave: %0d bad samples, want 0", errs);
        else n_pass++;
        n_total++;
        if (nlow != 1) $display("FAIL reject_idle_gap: busy low %0d cycles, want 1", nlow);
        else n_pass++;
        n_total++;
        if ({cap_done[80], cap_busy[81], cap_tx[81]} !== 3'b110)
            $display("FAIL reject_restart: done80/busy81/tx81=%b want 110",
                     {cap_done[80], cap_busy[81], cap_tx[81]});
        else n_pass++;
        for (int b = 0; b < 4; b++) begin
            n_total++;
            if (dec[b] !== want[b])
                $display("FAIL reject_byte%0d: got %h want %h", b, dec[b], want[b]);
            else n_pass++;
        end
    endtask

    task automatic test_freeze();
        logic [7:0] v = 8'($urandom);
        int errs  = 0;
        int nhold = 0;
        int nb    = 0;
        int j;
        wait_idle();
        sel = 1;
        capture(v, 90, 57, 7, 1'b0);
        for (int k = 0; k < 90; k++) begin
            j = (k < 57) ? k : (k < 64) ? 56 : k - 7;
            if (cap_tx[k] !== exp_tx(v, 4, 2, j) || cap_busy[k] !== (j < 80) ||
                cap_done[k] !== (j == 80)) errs++;
            if (k >= 57 && k < 64 && cap_tx[k] !== cap_tx[56]) nhold++;
            if (cap_busy[k]) nb++;
        end
        decode(4, 2);
        n_total++;
        if (errs != 0) $display("FAIL freeze_wave %h: %0d bad samples, want 0", v, errs);
        else n_pass++;
        n_total++;
        if (nhold != 0) $display("FAIL freeze_hold: %0d tx changes, want 0", nhold);
        else n_pass++;
        n_total++;
        if (nb != 87) $display("FAIL freeze_busy: got %0d want 87", nb);
        else n_pass++;
        for (int b = 0; b < 2; b++) begin
            n_total++;
            if (dec[b] !== exp_char(v, b))
                $display("FAIL freeze_byte%0d: got %h want %h", b, dec[b], exp_char(v, b));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic b_before;
        int nb = 0;
        wait_idle();
        sel = 1;
        @(negedge clk);
        count_in = 8'($urandom);
        send     = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        b_before = busy_s;
        rst_n    = 1'b0;
        #1;
        n_total++;
        if (b_before !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", b_before);
        else n_pass++;
        n_total++;
        if ({tx_s, busy_s, done_s} !== 3'b100)
            $display("FAIL rstmid_async: tx/busy/done=%b want 100", {tx_s, busy_s, done_s});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        capture(8'hA5, 83, 0, 0, 1'b0);
        for (int k = 0; k < 83; k++) if (cap_busy[k]) nb++;
        decode(4, 2);
        n_total++;
        if (nb != 80) $display("FAIL rstmid_busy_len: got %0d want 80", nb);
        else n_pass++;
        n_total++;
        if (dec[0] !== 8'h41) $display("FAIL rstmid_byte0: got %h want 41", dec[0]);
        else n_pass++;
        n_total++;
        if (dec[1] !== 8'h35) $display("FAIL rstmid_byte1: got %h want 35", dec[1]);
        else n_pass++;
    endtask

    task automatic test_long_baud();
        logic [7:0] v = 8'h00;
        int errs  = 0;
        int nb    = 0;
        int nstop = 0;
        int nrun  = 0;
        int run   = 1;
        wait_idle();
        sel = 2;
        capture(v, 483, 0, 0, 1'b0);
        for (int k = 0; k < 483; k++) begin
            if (cap_tx[k] !== exp_tx(v, 16, 3, k) || cap_busy[k] !== (k < 480) ||
                cap_done[k] !== (k == 480)) errs++;
            if (cap_busy[k]) nb++;
        end
        for (int f = 0; f < 3; f++)
            for (int k = 144; k < 160; k++)
                if (cap_tx[f * 160 + k] !== 1'b1) nstop++;
        for (int k = 1; k < 480; k++) begin
            if (cap_tx[k] === cap_tx[k - 1]) run++;
            else begin
                if (run % 16 != 0) nrun++;
                run = 1;
            end
        end
        decode(16, 3);
        n_total++;
        if (errs != 0) $display("FAIL long_wave: %0d bad samples, want 0", errs);
        else n_pass++;
        n_total++;
        if (nb != 480) $display("FAIL long_busy: got %0d want 480", nb);
        else n_pass++;
        n_total++;
        if ({cap_busy[479], cap_busy[480], cap_done[480]} !== 3'b101)
            $display("FAIL long_done: busy479/busy480/done480=%b want 101",
                     {cap_busy[479], cap_busy[480], cap_done[480]});
        else n_pass++;
        n_total++;
        if (nstop != 0) $display("FAIL long_stop: %0d low stop samples, want 0", nstop);
        else n_pass++;
        n_total++;
        if (nrun != 0) $display("FAIL long_bitlen: %0d runs not multiple of 16, want 0", nrun);
        else n_pass++;
        for (int b = 0; b < 3; b++) begin
            n_total++;
            if (dec[b] !== exp_char(v, b))
                $display("FAIL long_byte%0d: got %h want %h", b, dec[b], exp_char(v, b));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hex_bounds();
        test_busy_reject();
        test_freeze();
        test_reset_mid();
        test_long_baud();
        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Serial readout for the TinyTapeout counter design. On a send request it snapshots an 8-bit count value and transmits it as two uppercase ASCII hex characters, with an optional trailing CR, over 8N1 UART on a single output pin. The counter block drives it, and its tx pin maps to one uo_out bit, so an external host can read the count back.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range is 2 or more.
APPEND_CR, 1, when 1 a 0x0D character follows the two hex characters; when 0 only two characters are sent.

Ports:
clk  input  1  system clock, the only clock.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  design enable; low freezes all state.
count_in  input  8  count value; sampled only when a send is accepted.
send  input  1  level-sampled send request.
tx  output  1  UART line; idles high.
busy  output  1  high while a message is in flight.
done  output  1  one-cycle pulse when the message completes.

Behaviour:
- Reset (rst_n low, asynchronous): tx=1, busy=0, done=0. State goes to IDLE and all counters and the snapshot are cleared. Reset mid-frame aborts the message at once; tx returns high with no partial stop bit.
- States: IDLE, START, DATA, STOP.
- Acceptance: at a rising edge with ena=1, state IDLE and send=1:
  - count_in is latched into snap and char index is set to 0.
  - From that edge, tx=0 (start bit) and busy=1.
  - send is ignored whenever busy=1, including the edge at which busy falls.
- Character sequence:
  - char0 = hex(snap[7:4]), char1 = hex(snap[3:0]), then char2 = 0x0D if APPEND_CR=1.
  - hex(n) = 0x30+n for n=0..9; 0x41+(n-10) for n=10..15.
- Frame per character: start bit 0, data bits 0..7 LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT enabled cycles. Frame length is 10*CLKS_PER_BIT cycles.
- Transitions:
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - At the end of STOP: if more characters remain, go directly to START of the next character with no idle gap. Otherwise go to IDLE.
- Completion: the last stop bit ends at edge T = acceptance edge + NCHAR*10*CLKS_PER_BIT, where NCHAR = 2+APPEND_CR.
  - At edge T: busy=0, done=1, tx=1.
  - done clears at the next edge.
  - The earliest new acceptance is edge T+1.
- ena=0: baud counter, bit index, char index and state all hold. tx and busy hold their values. send is ignored. done is forced to 0; a done pulse due during a frozen cycle is deferred to the first enabled cycle.
- Width rules:
  - Baud counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index is 3 bits; char index is 2 bits.
- All outputs are registered; no combinational path from inputs to outputs.
- count_in changing during a transmission has no effect; only snap is used.

Test Plan:
- Basic message, CLKS_PER_BIT=4, APPEND_CR=1: pulse send with count_in=0x3A.
  - Bench decodes bytes 0x33, 0x41, 0x0D.
  - busy is high for exactly 120 cycles; done pulses once at cycle 120 after acceptance.
  - tx low at cycle 0, at 40 and at 80 (start bits), with no idle between frames.
- Hex boundaries, APPEND_CR=0: send count_in=0x09 → 0x30, 0x39 with busy for 80 cycles; count_in=0xF0 → 0x46, 0x30; count_in=0xFF → 0x46, 0x46.
- Busy rejection: hold send high continuously with count_in=0x12, then change count_in to 0x34 mid-message.
  - The first message carries 0x31, 0x32.
  - A second message starts exactly one cycle after done and carries 0x33, 0x34.
  - Assert no acceptance occurs while busy=1.
- ena freeze: deassert ena for 7 cycles in the middle of data bit 3 of char1.
  - tx holds its value for those 7 cycles.
  - Total busy time is 87 cycles (80+7) and the decoded bytes are unchanged.
- Reset mid-operation: assert rst_n=0 asynchronously, between clock edges, during char0's data bits.
  - tx=1, busy=0 and done=0 immediately.
  - After release, a new send with count_in=0xA5 transmits 0x41, 0x35 cleanly.
- Long-baud check, CLKS_PER_BIT=16: count_in=0x00.
  - Each bit measures exactly 16 cycles.
  - Stop bits are high for 16 cycles; done is coincident with busy falling at cycle 480 (APPEND_CR=1).
